// File: rtl/arith_seq_ctrl.sv
// Sequencer for the shared 16-bit arithmetic datapath: ADD/SUB latency 1, MUL/DIV latency STEP_CYCLES+2.
// One op in flight; the request side stalls (in_ready low) until the held response is consumed.

// Combinational 16-bit adder, wraps mod 2^16.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    assign sum = a + b;
endmodule

// Combinational 16-bit subtractor, wraps mod 2^16.
module subtractor16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] diff
);
    assign diff = a - b;
endmodule

// Shift-add multiplier: product final 16 steps after load, then stays put.
module mul16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] product
);
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= {mcand[14:0], 1'b0};
            mplier <= {1'b0, mplier[15:1]};
        end
    end

    assign product = acc;
endmodule

// Restoring divider: quotient final 16 steps after load; it keeps shifting afterwards.
module div16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] quotient
);
    logic [15:0] rem;
    logic [15:0] quo;
    logic [15:0] dvs;
    logic [16:0] shifted;
    logic [16:0] trial;

    assign shifted = {rem, quo[15]};
    assign trial   = shifted - {1'b0, dvs};

    // Bit 16 of the trial difference is the borrow: set means the divisor did not fit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= a;
            dvs <= b;
        end else if (!trial[16]) begin
            rem <= trial[15:0];
            quo <= {quo[14:0], 1'b1};
        end else begin
            rem <= shifted[15:0];
            quo <= {quo[14:0], 1'b0};
        end
    end

    assign quotient = quo;
endmodule

module arith_seq_ctrl #(
    parameter int WIDTH       = 16,
    parameter int STEP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_div_zero
);
    localparam int CNT_W = $clog2(STEP_CYCLES) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              mul_load;
    logic              div_load;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  product;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  capture_result;
    logic              capture_dz;

    assign accept = in_valid && in_ready && (state == S_IDLE);

    adder16      u_add (.a(a_q), .b(b_q), .sum(sum));
    subtractor16 u_sub (.a(a_q), .b(b_q), .diff(diff));
    mul16        u_mul (.clk(clk), .reset(reset), .load(mul_load), .a(a_q), .b(b_q), .product(product));
    div16        u_div (.clk(clk), .reset(reset), .load(div_load), .a(a_q), .b(b_q), .quotient(quotient));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Single-cycle ops and divide-by-zero skip the units and finalise through CAPTURE directly.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_op == OP_MUL || (in_op == OP_DIV && in_b != '0))
                        next_state = S_LOAD;
                    else
                        next_state = S_CAPTURE;
                end
            end
            S_LOAD:    next_state = S_RUN;
            S_RUN:     if (cnt == CNT_W'(STEP_CYCLES - 1)) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_RESP;
            S_RESP:    if (out_valid && out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mul_load       = (state == S_LOAD) && (op_q == OP_MUL);
        div_load       = (state == S_LOAD) && (op_q == OP_DIV);
        capture_dz     = 1'b0;
        capture_result = sum;
        case (op_q)
            OP_ADD: capture_result = sum;
            OP_SUB: capture_result = diff;
            OP_MUL: capture_result = product;
            OP_DIV: begin
                if (b_q == '0) begin
                    capture_result = '1;
                    capture_dz     = 1'b1;
                end else begin
                    capture_result = quotient;
                end
            end
            default: capture_result = sum;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_div_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= in_op;
                a_q  <= in_a;
                b_q  <= in_b;
            end
            if (state == S_LOAD)
                cnt <= '0;
            else if (state == S_RUN)
                cnt <= cnt + CNT_W'(1);
            in_ready  <= (next_state == S_IDLE);
            out_valid <= (next_state == S_RESP);
            if (state == S_CAPTURE) begin
                out_result   <= capture_result;
                out_div_zero <= capture_dz;
            end else if (state == S_RESP && out_ready) begin
                out_div_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl: latency, results, back-pressure and async reset.
module tb_arith_seq_ctrl;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_div_zero;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    arith_seq_ctrl #(.WIDTH(16), .STEP_CYCLES(16)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_div_zero(out_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
    endtask

    // Returns the number of edges from the accept edge until out_valid is seen.
    task automatic wait_resp(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_dz, input int exp_lat, input int hold);
        int n;
        wait_ready(tag);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'h0000; in_op = OP_ADD;
        wait_resp(n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_dz"}, out_div_zero, exp_dz);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check({tag, "_hold_vld"}, out_valid, 1);
            check({tag, "_hold_res"}, out_result, exp_res);
            check({tag, "_hold_rdy"}, in_ready, 0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_done_vld"}, out_valid, 0);
        check({tag, "_done_rdy"}, in_ready, 1);
        check({tag, "_done_dz"}, out_div_zero, 0);
    endtask

    initial begin
        int n;
        int stray;
        reset = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_div_zero", out_div_zero, 0);
        #5 reset = 1'b1;
        #1 check("rel_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        check("rel_in_ready_high", in_ready, 1);

        run_op("add", OP_ADD, 16'hFFE7, 16'd64, 16'd39, 1'b0, 1, 0);
        run_op("sub", OP_SUB, 16'd5, 16'd9, 16'hFFFC, 1'b0, 1, 0);
        run_op("mul_small", OP_MUL, 16'd3, 16'd55, 16'd165, 1'b0, 18, 0);
        run_op("mul_wrap", OP_MUL, 16'd300, 16'd300, 16'd24464, 1'b0, 18, 0);
        run_op("div_5_1", OP_DIV, 16'd5, 16'd1, 16'd5, 1'b0, 18, 0);
        run_op("div_100_7", OP_DIV, 16'd100, 16'd7, 16'd14, 1'b0, 18, 6);
        run_op("div_ffff", OP_DIV, 16'hFFFF, 16'hFFFF, 16'd1, 1'b0, 18, 4);
        run_op("div_zero", OP_DIV, 16'd123, 16'd0, 16'hFFFF, 1'b1, 1, 0);
        run_op("add_after_dz", OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0, 1, 0);

        // Back-pressure with a competing request held on the input.
        wait_ready("bp");
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_MUL; in_a = 16'd9; in_b = 16'd3;
        @(posedge clk); #1;
        in_op = OP_ADD; in_a = 16'd1; in_b = 16'd2;
        check("bp_busy_rdy", in_ready, 0);
        wait_resp(n);
        check("bp_lat", n, 18);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_vld", out_valid, 1);
            check("bp_hold_res", out_result, 16'd27);
            check("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_rdy", in_ready, 1);
        check("bp_release_vld", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_add_taken_rdy", in_ready, 0);
        wait_resp(n);
        check("bp_add_lat", n, 1);
        check("bp_add_res", out_result, 16'd3);
        @(posedge clk); #1;
        check("bp_add_done_rdy", in_ready, 1);

        // Async reset in the middle of a DIV run.
        wait_ready("ar");
        in_valid = 1'b1; in_op = OP_DIV; in_a = 16'd100; in_b = 16'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("ar_in_ready", in_ready, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_result", out_result, 0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("ar_rel_rdy", in_ready, 1);
        stray = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check("ar_no_resp", stray, 0);
        run_op("ar_mul", OP_MUL, 16'd3, 16'd55, 16'd165, 1'b0, 18, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_seq_ctrl.md
Name: arith_seq_ctrl

Overview:
Sequencing controller for the shared 16-bit arithmetic datapath. It accepts one operation at a time (ADD, SUB, MUL, DIV) over a valid/ready request channel. Single-cycle ops go through adder16/subtractor16. MUL/DIV go through one instance each of mul16/div16: the controller drives their active-high synchronous load, counts the step cycles, and captures the result on the exact cycle it is final. The result is held on a valid/ready response channel until consumed.

Parameters:
WIDTH, 16, operand/result width; fixed by the datapath units, only 16 is supported.
STEP_CYCLES, 16, unit step edges after load until the mul16/div16 result is final.

Ports:
clk  input  1  clock, all state on posedge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
in_valid  input  1  request valid.
in_ready  output  1  controller can accept a request.
in_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
in_a  input  16  operand A (dividend for DIV).
in_b  input  16  operand B (divisor for DIV).
out_valid  output  1  response valid.
out_ready  input  1  consumer accepts the response.
out_result  output  16  result, unsigned mod 2^16.
out_div_zero  output  1  DIV with in_b == 0.

Behaviour:
- Reset (reset == 0, async): state IDLE, in_ready 0, out_valid 0, out_result 0, out_div_zero 0, step counter 0, mul/div load deasserted. in_ready goes to 1 on the first posedge after release.
- in_ready and out_* are registered. Accept = in_valid & in_ready at a posedge. One op in flight; no accept outside IDLE.
- On accept: latch op/a/b into internal registers and clear in_ready.
- IDLE -> accept ADD/SUB -> RESP. out_result = latched a+b or a-b (adder16/subtractor16 on latched operands), wraps mod 2^16. out_valid = 1 after the edge following accept (latency 1).
- IDLE -> accept DIV with b == 0 -> RESP. out_result 0xFFFF, out_div_zero 1, latency 1. The div unit is not started.
- IDLE -> accept MUL / DIV (b != 0) -> LOAD.
  - LOAD (1 cycle): assert the selected unit's load with the latched operands; only the selected unit is loaded.
  - -> RUN, step counter 0.
  - RUN: load deasserted; counter +1 per edge; leave after STEP_CYCLES edges (counter == STEP_CYCLES-1) -> CAPTURE.
  - CAPTURE (1 cycle): register the unit output into out_result, out_div_zero 0 -> RESP.
  - Accept-edge to out_valid latency = STEP_CYCLES + 2 = 18 edges.
  - The div unit keeps shifting after the final step. Capture must occur exactly at CAPTURE; capturing one cycle late is a bug.
- RESP: out_valid 1, out_result/out_div_zero stable while out_ready == 0.
  - On out_valid & out_ready at an edge: out_valid 0, out_div_zero 0, in_ready 1, state IDLE. out_result keeps its last value.
  - No same-cycle accept in RESP. The earliest new accept is the edge after the response handshake.
- in_valid while busy: ignored, in_ready stays 0. Requester must hold in_valid/op/a/b until accepted; inputs changing while busy have no effect.
- in_op/in_a/in_b are sampled only at the accept edge.
- Reset asserted mid-LOAD/RUN/CAPTURE/RESP: immediate return to reset values. The in-flight op is discarded, no response. mul16/div16 internal state is don't-care until the next LOAD.
- Illegal state encodings recover to IDLE.
- Step counter width: ceil(log2(STEP_CYCLES))+1 bits; no wrap in normal operation.

Test Plan:
1. ADD a=0xFFE7 (-25), b=64, out_ready=1 -> out_valid one edge after accept, out_result 39 (0x0027), div_zero 0. SUB a=5, b=9 -> out_result 0xFFFC (-4 signed).
2. MUL a=3, b=55 -> out_valid exactly 18 edges after accept, out_result 165. MUL a=300, b=300 -> 24464 (overflow wraps).
3. DIV a=5, b=1 -> 5 at 18 edges. DIV a=100, b=7 -> 14. DIV a=0xFFFF, b=0xFFFF -> 1. Check out_result is captured and stable after capture although the unit keeps shifting.
4. DIV a=123, b=0 -> one edge latency, out_result 0xFFFF, out_div_zero 1. Next op ADD 1+1 -> 2, out_div_zero 0.
5. Back-pressure: MUL 9*3 with out_ready=0 for 10 cycles -> out_valid held, result 27 stable, in_ready 0. A concurrent in_valid with ADD is ignored. Raise out_ready -> in_ready 1 next edge, ADD then accepted.
6. Async reset: drop reset at RUN step 7 of DIV 100/7, between edges -> out_valid/in_ready 0 immediately, no response after release. in_ready 1 one edge after release. A new MUL 3*55 then returns 165 at 18 edges.
